systolic_feeder: RTL

Transmit side of the systolic array's west/north operand interface. It captures two SIZE x SIZE 8-bit matrices A and B on a start request. It then drives the skewed (diagonal) operand wavefronts into the array's in_west/in_north ports, waits for the array's done, and reports completion. It replaces hand-driven stimulus and sits between the NPU controller and systolic_array.

---
 rtl/npu_pkg.sv | 20 ++
 rtl/systolic_feeder_skew.sv | 28 ++
 rtl/systolic_feeder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared NPU types: feeder FSM states, feed length helper, operand width.
package npu_pkg;

  localparam int unsigned DW_DEFAULT = 8;

  typedef logic [DW_DEFAULT-1:0] operand_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } feeder_state_t;

  function automatic int unsigned feed_len(input int unsigned size);
    return 3 * size - 2;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew.sv
// Diagonal wavefront selector: element e carries mat[e][k-e] (rows) or
// mat[k-e][e] (columns), zero where the diagonal falls outside the matrix.
module skew_select
  import npu_pkg::*;
#(
  parameter int unsigned SIZE   = 4,
  parameter int unsigned DW     = DW_DEFAULT,
  parameter int unsigned KW     = 4,
  parameter bit          COLUMN = 1'b0
) (
  input  logic [KW-1:0]                      k,
  input  logic [SIZE-1:0][SIZE-1:0][DW-1:0]  mat,
  output logic [SIZE-1:0][DW-1:0]            wave
);

  // Matching e + d against k avoids signed k - e arithmetic.
  always_comb begin
    wave = '0;
    for (int unsigned e = 0; e < SIZE; e++) begin
      for (int unsigned d = 0; d < SIZE; d++) begin
        if (32'(k) == e + d) begin
          wave[e] = COLUMN ? mat[d][e] : mat[e][d];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Captures A/B on start, streams skewed operand wavefronts into the systolic
// array, then waits (bounded) for the array's done and reports completion.
module systolic_feeder
  import npu_pkg::*;
#(
  parameter int unsigned SIZE      = 4,
  parameter int unsigned DW        = DW_DEFAULT,
  parameter int unsigned DRAIN_MAX = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [SIZE-1:0][SIZE-1:0][DW-1:0]  a_mat,
  input  logic [SIZE-1:0][SIZE-1:0][DW-1:0]  b_mat,
  output logic [SIZE-1:0][DW-1:0]            out_west,
  output logic [SIZE-1:0][DW-1:0]            out_north,
  output logic                               out_valid,
  output logic                               array_clr,
  input  logic                               array_done,
  output logic                               busy,
  output logic                               done,
  output logic                               timeout
);

  localparam int unsigned FEED_LEN = feed_len(SIZE);
  localparam int unsigned KW       = $clog2(3 * SIZE - 1);
  localparam int unsigned CW       = $clog2(DRAIN_MAX + 1);

  feeder_state_t state_q, state_n;
  logic [KW-1:0] step_q, step_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          timeout_n;
  logic          latch;

  logic [SIZE-1:0][SIZE-1:0][DW-1:0] a_q, b_q;
  logic [SIZE-1:0][DW-1:0]           west_wave, north_wave;

  skew_select #(
    .SIZE   (SIZE),
    .DW     (DW),
    .KW     (KW),
    .COLUMN (1'b0)
  ) u_skew_west (
    .k    (step_n),
    .mat  (a_q),
    .wave (west_wave)
  );

  skew_select #(
    .SIZE   (SIZE),
    .DW     (DW),
    .KW     (KW),
    .COLUMN (1'b1)
  ) u_skew_north (
    .k    (step_n),
    .mat  (b_q),
    .wave (north_wave)
  );

  always_comb begin
    state_n   = state_q;
    step_n    = step_q;
    cnt_n     = cnt_q;
    timeout_n = timeout;
    latch     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_n   = CLEAR;
          latch     = 1'b1;
          timeout_n = 1'b0;
        end
      end
      CLEAR: begin
        state_n = FEED;
        step_n  = '0;
      end
      FEED: begin
        if (step_q == KW'(FEED_LEN - 1)) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else begin
          step_n = step_q + KW'(1);
        end
      end
      DRAIN: begin
        // array_done takes priority over the timeout in the final wait cycle.
        if (array_done) begin
          state_n = DONE;
        end else if (cnt_q == CW'(DRAIN_MAX - 1)) begin
          state_n   = DONE;
          timeout_n = 1'b1;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      out_west  <= '0;
      out_north <= '0;
      out_valid <= 1'b0;
      array_clr <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_n;
      step_q    <= step_n;
      cnt_q     <= cnt_n;
      timeout   <= timeout_n;
      if (latch) begin
        a_q <= a_mat;
        b_q <= b_mat;
      end
      out_valid <= (state_n == FEED);
      array_clr <= (state_n == CLEAR);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      out_west  <= (state_n == FEED) ? west_wave  : '0;
      out_north <= (state_n == FEED) ? north_wave : '0;
    end
  end

endmodule
